// File: rtl/pipe_pkg.sv
// Shared definitions for femtoRV32 pipeline stage registers: occupancy state encodings
// and the default datapath width.
package pipe_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/load_reg.sv
// Plain n-bit register with synchronous active-high reset and load enable.
module load_reg #(
  parameter int unsigned        WIDTH   = 32,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= RST_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid buffer so that
// in_ready can be registered without losing throughput.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH   = XLEN,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             w_accept;
  logic             w_drain;
  logic             w_main_en;
  logic             w_main_sel_skid;
  logic             w_skid_en;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;

  assign w_accept = in_valid & r_in_ready;
  assign w_drain  = r_out_valid & out_ready;

  // Flush only clears occupancy; data registers keep their contents.
  always_comb begin
    w_state_nxt     = r_state;
    w_main_en       = 1'b0;
    w_main_sel_skid = 1'b0;
    w_skid_en       = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_main_en   = 1'b1;
            w_state_nxt = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_accept && !w_drain) begin
            w_skid_en   = 1'b1;
            w_state_nxt = ST_FULL;
          end else if (w_accept && w_drain) begin
            w_main_en   = 1'b1;
          end else if (w_drain) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_drain) begin
            w_main_en       = 1'b1;
            w_main_sel_skid = 1'b1;
            w_state_nxt     = ST_BUSY;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  assign w_main_d = w_main_sel_skid ? w_skid_q : in_data;

  // Handshake flags are registered copies of the next-state decode, keeping
  // out_ready -> in_ready free of combinational paths.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != ST_FULL);
      r_out_valid <= (w_state_nxt != ST_EMPTY);
    end
  end

  load_reg #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) u_main (
    .i_clk (clk),
    .i_rst (rst),
    .i_en  (w_main_en),
    .i_d   (w_main_d),
    .o_q   (w_main_q)
  );

  load_reg #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) u_skid (
    .i_clk (clk),
    .i_rst (rst),
    .i_en  (w_skid_en),
    .i_d   (in_data),
    .o_q   (w_skid_q)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = w_main_q;
  assign count     = r_state;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg; a second instance with a non-zero reset value shares
// the same stimulus to check reset of the data registers.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        a_in_ready, a_out_valid;
  logic [31:0] a_out_data;
  logic [1:0]  a_count;
  logic        b_in_ready, b_out_valid;
  logic [31:0] b_out_data;
  logic [1:0]  b_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (a_in_ready),
    .in_data   (in_data),
    .out_valid (a_out_valid),
    .out_ready (out_ready),
    .out_data  (a_out_data),
    .count     (a_count)
  );

  pipe_stage_reg #(
    .WIDTH   (32),
    .RST_VAL (32'h13)
  ) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (b_in_ready),
    .in_data   (in_data),
    .out_valid (b_out_valid),
    .out_ready (out_ready),
    .out_data  (b_out_data),
    .count     (b_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [31:0] data, input logic vld,
                             input logic rdy, input logic [1:0] cnt);
    check_eq({tag, ".data"},  a_out_data,         data);
    check_eq({tag, ".valid"}, 32'(a_out_valid),   32'(vld));
    check_eq({tag, ".ready"}, 32'(a_in_ready),    32'(rdy));
    check_eq({tag, ".count"}, 32'(a_count),       32'(cnt));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b0;

    // Reset held two cycles while upstream offers data
    tick();
    tick();
    check_state("reset", 32'h0, 1'b0, 1'b1, 2'd0);
    check_eq("reset.b_data", b_out_data, 32'h13);
    rst = 1'b0; in_valid = 1'b0;
    tick();
    check_state("idle", 32'h0, 1'b0, 1'b1, 2'd0);

    // Streaming 1..4 with out_ready high
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      tick();
      check_state($sformatf("stream%0d", i), 32'(i), 1'b1, 1'b1, 2'd1);
    end
    in_valid = 1'b0;
    tick();
    check_state("stream_end", 32'h4, 1'b0, 1'b1, 2'd0);

    // Stall and skid
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    tick();
    check_state("skid_a", 32'hA, 1'b1, 1'b1, 2'd1);
    in_data = 32'hB;
    tick();
    check_state("skid_full", 32'hA, 1'b1, 1'b0, 2'd2);
    in_data = 32'hC;
    tick();
    check_state("skid_hold", 32'hA, 1'b1, 1'b0, 2'd2);
    out_ready = 1'b1;
    tick();
    check_state("skid_b", 32'hB, 1'b1, 1'b1, 2'd1);
    tick();
    check_state("skid_c", 32'hC, 1'b1, 1'b1, 2'd1);
    in_valid = 1'b0;
    tick();
    check_state("skid_end", 32'hC, 1'b0, 1'b1, 2'd0);

    // Flush in FULL with a word offered
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
    tick();
    in_data = 32'h22;
    tick();
    check_state("pre_flush", 32'h11, 1'b1, 1'b0, 2'd2);
    flush = 1'b1; in_data = 32'h55;
    tick();
    check_state("flush_full", 32'h11, 1'b0, 1'b1, 2'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check_state("post_flush", 32'h11, 1'b0, 1'b1, 2'd0);

    // Flush in BUSY discards a simultaneous accept
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h66;
    tick();
    flush = 1'b1; in_data = 32'h77;
    tick();
    check_state("flush_busy", 32'h66, 1'b0, 1'b1, 2'd0);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    check_state("flush_busy_idle", 32'h66, 1'b0, 1'b1, 2'd0);

    // Simultaneous accept and drain in BUSY, then hold under stall
    in_valid = 1'b1; in_data = 32'h10;
    tick();
    out_ready = 1'b1; in_data = 32'h20;
    tick();
    check_state("acc_drain", 32'h20, 1'b1, 1'b1, 2'd1);
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    check_state("stall_hold", 32'h20, 1'b1, 1'b1, 2'd1);
    out_ready = 1'b1;
    tick();
    check_state("drain_only", 32'h20, 1'b0, 1'b1, 2'd0);

    // Reset mid-operation from FULL
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h31;
    tick();
    in_data = 32'h32;
    tick();
    check_eq("pre_rst.b_count", 32'(b_count), 32'd2);
    check_eq("pre_rst.b_data", b_out_data, 32'h31);
    rst = 1'b1; in_data = 32'h99;
    tick();
    check_eq("rst_mid.b_data",  b_out_data,        32'h13);
    check_eq("rst_mid.b_valid", 32'(b_out_valid),  32'd0);
    check_eq("rst_mid.b_ready", 32'(b_in_ready),   32'd1);
    check_eq("rst_mid.b_count", 32'(b_count),      32'd0);
    check_state("rst_mid_a", 32'h0, 1'b0, 1'b1, 2'd0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check_eq("rst_after.b_data",  b_out_data,       32'h13);
    check_eq("rst_after.b_valid", 32'(b_out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
